// File: rtl/usb_pkg.sv
// usb_pkg: PID codes, token field offsets and controller state encoding
package usb_pkg;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam int TOK_PID  = 0;
  localparam int TOK_ADDR = 8;
  localparam int TOK_ENDP = 15;
  typedef enum logic [2:0] {IDLE, RX_DATA, HS_START, HS_WAIT, TX_START, TX_DATA, TX_WAIT_ACK} state_t;
endpackage

// File: rtl/usb_ep_state.sv
// usb_ep_state: per-endpoint DATA0/DATA1 toggle bits
module usb_ep_state #(
  parameter int N_EP = 4,
  parameter int EPW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_en,
  input  logic [EPW-1:0] set_ep,
  input  logic           flip_en,
  input  logic [EPW-1:0] flip_ep,
  input  logic [EPW-1:0] rd_ep,
  output logic           rd_tog
);
  logic [N_EP-1:0] tog;
  always_ff @(posedge clk) begin
    if (rst) tog <= '0;
    else begin
      if (set_en) tog[set_ep] <= 1'b1;
      if (flip_en) tog[flip_ep] <= ~tog[flip_ep];
    end
  end
  assign rd_tog = tog[rd_ep];
endmodule

// File: rtl/usb_ep_ctrl_multi.sv
// usb_ep_ctrl_multi: multi-endpoint USB token/data/handshake controller
module usb_ep_ctrl_multi import usb_pkg::*; #(
  parameter int N_EP = 4,
  parameter int BUF_DEPTH = 64,
  parameter int ACK_TIMEOUT = 1000,
  localparam int LENW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           dev_addr,
  input  logic [23:0]          token_in,
  input  logic                 token_in_strb,
  input  logic [7:0]           data_in,
  input  logic                 data_in_strb,
  input  logic                 data_in_end,
  input  logic                 data_in_fail,
  input  logic [N_EP-1:0]      ep_stall,
  input  logic [N_EP-1:0]      rx_busy,
  input  logic [N_EP-1:0]      tx_ready,
  input  logic [N_EP*LENW-1:0] tx_len,
  output logic                 rx_wr_en,
  output logic [LENW-1:0]      rx_wr_addr,
  output logic [7:0]           rx_wr_data,
  output logic                 rx_done,
  output logic [3:0]           rx_ep,
  output logic [LENW-1:0]      rx_len,
  output logic                 rx_setup,
  output logic                 tx_rd_en,
  output logic [3:0]           tx_rd_ep,
  output logic [LENW-1:0]      tx_rd_addr,
  input  logic [7:0]           tx_rd_data,
  output logic                 tx_done,
  output logic [7:0]           data_o,
  output logic                 data_o_start_stop,
  input  logic                 data_o_strb,
  input  logic                 data_o_fail
);
  localparam int EPW = N_EP > 1 ? $clog2(N_EP) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [LENW-1:0] MAXLEN = LENW'(BUF_DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  state_t state, nxt;
  logic [EPW-1:0] ep_q, tep;
  logic [LENW-1:0] cnt, idx, len_q;
  logic [TW-1:0] tmr;
  logic [7:0] hs_pid, byte_q, tok_pid;
  logic [3:0] tok_ep;
  logic setup_q, pid_seen, pid_odd, rd_vld, tog, tok_ok, tx_last, rx_blk;
  logic rx_end, rx_commit, ack_ok, set_en, flip_en, unused_crc;
  assign unused_crc = ^token_in[23:19];
  assign tok_pid = token_in[TOK_PID+:8];
  assign tok_ep = token_in[TOK_ENDP+:4];
  assign tep = EPW'(tok_ep);
  assign tok_ok = token_in_strb && token_in[TOK_ADDR+:7] == dev_addr && 5'(tok_ep) < 5'(N_EP) &&
                  (tok_pid == PID_SETUP || tok_pid == PID_OUT || tok_pid == PID_IN);
  assign tx_last = len_q == '0 || idx == len_q - 1'b1;
  assign rx_blk = !setup_q && (ep_stall[ep_q] || rx_busy[ep_q]);
  assign rx_end = state == RX_DATA && !data_in_fail && !data_in_strb && data_in_end && pid_seen;
  assign rx_commit = rx_end && (setup_q || (!rx_blk && pid_odd == tog));
  assign ack_ok = state == TX_WAIT_ACK && token_in_strb && tok_pid == PID_ACK && !data_o_fail;
  assign set_en = rx_end && setup_q;
  assign flip_en = (rx_commit && !setup_q) || ack_ok;
  assign tx_rd_ep = 4'(ep_q);
  usb_ep_state #(.N_EP(N_EP), .EPW(EPW)) u_state (
    .clk(clk), .rst(rst), .set_en(set_en), .set_ep(ep_q), .flip_en(flip_en),
    .flip_ep(ep_q), .rd_ep(ep_q), .rd_tog(tog)
  );
  always_comb begin
    nxt = state;
    data_o = '0;
    data_o_start_stop = 1'b0;
    tx_rd_en = 1'b0;
    tx_rd_addr = '0;
    case (state)
      IDLE: if (tok_ok) nxt = tok_pid != PID_IN ? RX_DATA : (ep_stall[tep] || !tx_ready[tep]) ? HS_START : TX_START;
      RX_DATA: begin
        if (data_in_fail) nxt = IDLE;
        else if (data_in_strb) nxt = (!pid_seen && data_in != PID_DATA0 && data_in != PID_DATA1) ||
                                     (pid_seen && cnt == MAXLEN) ? IDLE : RX_DATA;
        else if (data_in_end) nxt = pid_seen ? HS_START : IDLE;
      end
      HS_START: begin
        data_o = hs_pid;
        data_o_start_stop = 1'b1;
        nxt = HS_WAIT;
      end
      HS_WAIT: begin
        data_o_start_stop = data_o_strb;
        nxt = data_o_strb ? IDLE : HS_WAIT;
      end
      TX_START: begin
        data_o = tog ? PID_DATA1 : PID_DATA0;
        data_o_start_stop = 1'b1;
        tx_rd_en = 1'b1;
        nxt = data_o_fail ? IDLE : TX_DATA;
      end
      TX_DATA: begin
        data_o = rd_vld ? tx_rd_data : byte_q;
        tx_rd_addr = idx + 1'b1;
        data_o_start_stop = data_o_strb && tx_last;
        tx_rd_en = data_o_strb && !tx_last;
        nxt = data_o_fail ? IDLE : (data_o_strb && tx_last) ? TX_WAIT_ACK : TX_DATA;
      end
      TX_WAIT_ACK: nxt = (data_o_fail || token_in_strb || tmr == TMAX) ? IDLE : TX_WAIT_ACK;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {ep_q, cnt, idx, len_q, tmr, hs_pid, byte_q} <= '0;
      {setup_q, pid_seen, pid_odd, rd_vld} <= '0;
      {rx_wr_en, rx_wr_addr, rx_wr_data, rx_done, rx_ep, rx_len, rx_setup, tx_done} <= '0;
    end else begin
      state <= nxt;
      rx_wr_en <= 1'b0;
      rx_done <= rx_commit;
      tx_done <= ack_ok;
      rd_vld <= tx_rd_en;
      if (rd_vld) byte_q <= tx_rd_data;
      tmr <= state == TX_WAIT_ACK ? tmr + 1'b1 : '0;
      if (state == IDLE && tok_ok) begin
        ep_q <= tep;
        setup_q <= tok_pid == PID_SETUP;
        pid_seen <= 1'b0;
        cnt <= '0;
        idx <= '0;
        len_q <= tx_len[int'(tep)*LENW+:LENW];
        hs_pid <= ep_stall[tep] ? PID_STALL : PID_NAK;
      end
      if (state == RX_DATA && data_in_strb && !data_in_fail) begin
        if (!pid_seen) begin
          pid_seen <= 1'b1;
          pid_odd <= data_in == PID_DATA1;
        end else if (cnt != MAXLEN) begin
          rx_wr_en <= !rx_blk;
          rx_wr_addr <= cnt;
          rx_wr_data <= data_in;
          cnt <= cnt + 1'b1;
        end
      end
      if (rx_end) hs_pid <= setup_q ? PID_ACK : ep_stall[ep_q] ? PID_STALL : rx_busy[ep_q] ? PID_NAK : PID_ACK;
      if (rx_commit) begin
        rx_ep <= 4'(ep_q);
        rx_len <= cnt;
        rx_setup <= setup_q;
      end
      if (state == TX_DATA && data_o_strb && !tx_last) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_usb_ep_ctrl_multi.sv
// tb_usb_ep_ctrl_multi: directed scoreboard bench for usb_ep_ctrl_multi
module tb_usb_ep_ctrl_multi;
  import usb_pkg::*;
  localparam int N_EP = 4, BUF_DEPTH = 64, ACK_TIMEOUT = 1000, LENW = 7;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] dev_addr = '0;
  logic [23:0] token_in = '0;
  logic token_in_strb = 1'b0, data_in_strb = 1'b0, data_in_end = 1'b0, data_in_fail = 1'b0;
  logic [7:0] data_in = '0, tx_rd_data = '0;
  logic [N_EP-1:0] ep_stall = '0, rx_busy = '0, tx_ready = '1;
  logic [N_EP*LENW-1:0] tx_len = '0;
  logic rx_wr_en, rx_done, rx_setup, tx_rd_en, tx_done, data_o_start_stop;
  logic [LENW-1:0] rx_wr_addr, rx_len, tx_rd_addr;
  logic [7:0] rx_wr_data, data_o;
  logic [3:0] rx_ep, tx_rd_ep;
  logic data_o_strb = 1'b0, data_o_fail = 1'b0;
  logic [7:0] txmem [16][128];
  logic [8:0] q_tx[$];
  logic [14:0] q_wr[$];
  logic [11:0] q_rx[$];
  logic [3:0] q_done[$];
  logic [8:0] e_tx;
  logic [14:0] e_wr;
  logic [11:0] e_rx;
  logic [3:0] e_done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  usb_ep_ctrl_multi #(.N_EP(N_EP), .BUF_DEPTH(BUF_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .dev_addr(dev_addr), .token_in(token_in), .token_in_strb(token_in_strb),
    .data_in(data_in), .data_in_strb(data_in_strb), .data_in_end(data_in_end), .data_in_fail(data_in_fail),
    .ep_stall(ep_stall), .rx_busy(rx_busy), .tx_ready(tx_ready), .tx_len(tx_len),
    .rx_wr_en(rx_wr_en), .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data), .rx_done(rx_done),
    .rx_ep(rx_ep), .rx_len(rx_len), .rx_setup(rx_setup), .tx_rd_en(tx_rd_en), .tx_rd_ep(tx_rd_ep),
    .tx_rd_addr(tx_rd_addr), .tx_rd_data(tx_rd_data), .tx_done(tx_done), .data_o(data_o),
    .data_o_start_stop(data_o_start_stop), .data_o_strb(data_o_strb), .data_o_fail(data_o_fail)
  );

  always @(posedge clk) if (tx_rd_en) tx_rd_data <= txmem[tx_rd_ep][tx_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (data_o_start_stop || data_o_strb) begin
      if (q_tx.size() == 0) check("tx_unexpected", 32'(q_tx.size()), 32'd1);
      else begin
        e_tx = q_tx.pop_front();
        check("tx_data", 32'(data_o), 32'(e_tx[8:1]));
        check("tx_start_stop", 32'(data_o_start_stop), 32'(e_tx[0]));
      end
    end
    if (rx_wr_en) begin
      if (q_wr.size() == 0) check("wr_unexpected", 32'(q_wr.size()), 32'd1);
      else begin
        e_wr = q_wr.pop_front();
        check("rx_wr", 32'({rx_wr_addr, rx_wr_data}), 32'(e_wr));
      end
    end
    if (rx_done) begin
      if (q_rx.size() == 0) check("rx_done_unexpected", 32'(q_rx.size()), 32'd1);
      else begin
        e_rx = q_rx.pop_front();
        check("rx_done_qual", 32'({rx_ep, rx_len, rx_setup}), 32'(e_rx));
      end
    end
    if (tx_done) begin
      if (q_done.size() == 0) check("tx_done_unexpected", 32'(q_done.size()), 32'd1);
      else begin
        e_done = q_done.pop_front();
        check("tx_done_ep", 32'(tx_rd_ep), 32'(e_done));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic token(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep);
    token_in = {5'd0, ep, a, pid};
    token_in_strb = 1'b1;
    tick();
    token_in_strb = 1'b0;
  endtask

  task automatic packet(input logic [7:0] pid, input int n, input logic [7:0] base, input int step,
                        input bit expw, input int fail_at);
    data_in = pid;
    data_in_strb = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == fail_at) begin
        data_in_strb = 1'b0;
        data_in_fail = 1'b1;
        tick();
        data_in_fail = 1'b0;
        return;
      end
      data_in = base + 8'(i * step);
      if (expw && i < BUF_DEPTH) q_wr.push_back({7'(i), base + 8'(i * step)});
      tick();
    end
    data_in_strb = 1'b0;
    data_in_end = 1'b1;
    tick();
    data_in_end = 1'b0;
  endtask

  task automatic hs_end();
    tick();
    data_o_strb = 1'b1;
    tick();
    data_o_strb = 1'b0;
  endtask

  task automatic tx_strobes(input int n);
    tick();
    data_o_strb = 1'b1;
    tick(n);
    data_o_strb = 1'b0;
  endtask

  task automatic push_hs(input logic [7:0] pid);
    q_tx.push_back({pid, 1'b1});
    q_tx.push_back({8'h00, 1'b1});
  endtask

  task automatic push_in(input logic [7:0] pid, input int e, input int n);
    q_tx.push_back({pid, 1'b1});
    for (int i = 0; i < n; i++) q_tx.push_back({txmem[e][i], i == n - 1});
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_data_o"}, 32'(data_o), 32'd0);
    check({tag, "_ss"}, 32'(data_o_start_stop), 32'd0);
    check({tag, "_strobes"}, 32'({rx_wr_en, rx_done, tx_done, tx_rd_en}), 32'd0);
    check({tag, "_rx_qual"}, 32'({rx_ep, rx_len, rx_setup}), 32'd0);
    check({tag, "_addrs"}, 32'({rx_wr_addr, rx_wr_data, tx_rd_addr, tx_rd_ep}), 32'd0);
  endtask

  initial begin
    for (int e = 0; e < 16; e++) for (int i = 0; i < 128; i++) txmem[e][i] = 8'(16 * e + i + 1);
    for (int e = 0; e < N_EP; e++) tx_len[e*LENW+:LENW] = 7'd1;
    tx_len[3*LENW+:LENW] = 7'd3;
    tick(3);
    rst = 1'b0;
    tick();
    chk_idle("reset");
    // SETUP ep0: 8 bytes of 0x05
    push_hs(PID_ACK);
    q_rx.push_back({4'd0, 7'd8, 1'b1});
    token(PID_SETUP, 7'd0, 4'd0);
    packet(PID_DATA0, 8, 8'h05, 0, 1'b1, -1);
    hs_end();
    push_in(PID_DATA1, 0, 1);
    token(PID_IN, 7'd0, 4'd0);
    tx_strobes(1);
    token(PID_NAK, 7'd0, 4'd0);
    token(PID_IN, 7'd0, 4'd5);
    token(PID_IN, 7'd3, 4'd0);
    tick(3);
    // ep2: SETUP to reach DATA1, duplicate DATA0, fresh DATA1, then DATA0
    push_hs(PID_ACK);
    q_rx.push_back({4'd2, 7'd2, 1'b1});
    token(PID_SETUP, 7'd0, 4'd2);
    packet(PID_DATA0, 2, 8'h20, 1, 1'b1, -1);
    hs_end();
    push_hs(PID_ACK);
    token(PID_OUT, 7'd0, 4'd2);
    packet(PID_DATA0, 3, 8'h30, 1, 1'b1, -1);
    hs_end();
    push_hs(PID_ACK);
    q_rx.push_back({4'd2, 7'd4, 1'b0});
    token(PID_OUT, 7'd0, 4'd2);
    packet(PID_DATA1, 4, 8'h40, 3, 1'b1, -1);
    hs_end();
    push_hs(PID_ACK);
    q_rx.push_back({4'd2, 7'd1, 1'b0});
    token(PID_OUT, 7'd0, 4'd2);
    packet(PID_DATA0, 1, 8'h77, 1, 1'b1, -1);
    hs_end();
    token(PID_OUT, 7'd0, 4'd2);
    packet(PID_DATA1, BUF_DEPTH + 1, 8'h00, 1, 1'b1, -1);
    tick(3);
    // ep1 busy then stalled
    rx_busy = 4'b0010;
    push_hs(PID_NAK);
    token(PID_OUT, 7'd0, 4'd1);
    packet(PID_DATA0, 2, 8'h50, 1, 1'b0, -1);
    hs_end();
    ep_stall = 4'b0010;
    push_hs(PID_STALL);
    token(PID_OUT, 7'd0, 4'd1);
    packet(PID_DATA0, 2, 8'h50, 1, 1'b0, -1);
    hs_end();
    push_hs(PID_STALL);
    token(PID_IN, 7'd0, 4'd1);
    hs_end();
    ep_stall = '0;
    rx_busy = '0;
    tx_ready = 4'b1101;
    push_hs(PID_NAK);
    token(PID_IN, 7'd0, 4'd1);
    hs_end();
    tx_ready = '1;
    // IN ep3, 3 bytes, host ACK
    push_in(PID_DATA0, 3, 3);
    q_done.push_back(4'd3);
    token(PID_IN, 7'd0, 4'd3);
    tx_strobes(3);
    token(PID_ACK, 7'd0, 4'd0);
    tick(2);
    // IN ep3 without ACK, then retry with same toggle
    push_in(PID_DATA1, 3, 3);
    token(PID_IN, 7'd0, 4'd3);
    tx_strobes(3);
    tick(ACK_TIMEOUT + 2);
    push_in(PID_DATA1, 3, 3);
    q_done.push_back(4'd3);
    token(PID_IN, 7'd0, 4'd3);
    tx_strobes(3);
    token(PID_ACK, 7'd0, 4'd0);
    tick(2);
    // aborted OUT on ep0, then reset during TX_DATA
    token(PID_OUT, 7'd0, 4'd0);
    packet(PID_DATA1, 4, 8'h60, 1, 1'b1, 2);
    tick(4);
    q_tx.push_back({PID_DATA0, 1'b1});
    token(PID_IN, 7'd0, 4'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midreset");
    tick();
    tx_len = {N_EP{7'd1}};
    for (int e = 0; e < N_EP; e++) begin
      push_in(PID_DATA0, e, 1);
      token(PID_IN, 7'd0, 4'(e));
      tx_strobes(1);
      token(PID_NAK, 7'd0, 4'd0);
    end
    tick(3);
    check("q_tx_left", 32'(q_tx.size()), 32'd0);
    check("q_wr_left", 32'(q_wr.size()), 32'd0);
    check("q_rx_left", 32'(q_rx.size()), 32'd0);
    check("q_done_left", 32'(q_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
